// File: rtl/capture_trigger_controller_pkg.sv
// Shared definitions for the logic-analyzer capture sequencer:
// buffer address width and the capture FSM state encodings.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

package capture_trigger_controller_pkg;

  localparam int CAP_ADDR_WIDTH = `ADDR_WIDTH;

  localparam logic [2:0] CAP_ENC_IDLE  = 3'd0;
  localparam logic [2:0] CAP_ENC_CLEAR = 3'd1;
  localparam logic [2:0] CAP_ENC_FILL  = 3'd2;
  localparam logic [2:0] CAP_ENC_ARMED = 3'd3;
  localparam logic [2:0] CAP_ENC_POST  = 3'd4;
  localparam logic [2:0] CAP_ENC_DONE  = 3'd5;

  typedef enum logic [2:0] {
    CAP_IDLE  = CAP_ENC_IDLE,
    CAP_CLEAR = CAP_ENC_CLEAR,
    CAP_FILL  = CAP_ENC_FILL,
    CAP_ARMED = CAP_ENC_ARMED,
    CAP_POST  = CAP_ENC_POST,
    CAP_DONE  = CAP_ENC_DONE
  } cap_state_t;

endpackage

// File: rtl/capture_trigger_controller_post_trigger_counter.sv
// Post-trigger sample counter: loads N on the trigger cycle and counts down;
// last flags the final post-trigger write.
module capture_trigger_controller_post_trigger_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/capture_trigger_controller.sv
// Capture sequencer: clears and fills the history buffer, waits for a trigger,
// records N+1 samples from the trigger on, then freezes and reports addresses.
module capture_trigger_controller
  import capture_trigger_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = CAP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trigger_in,
  input  logic [ADDR_WIDTH-1:0] post_trig_count,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  primed,
  output logic                  buf_clear,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  busy,
  output logic                  done
);

  cap_state_t state;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_last;
  logic       trig_hit;

  assign trig_hit = (state == CAP_ARMED) && trigger_in;
  assign cnt_load = trig_hit && !abort;
  assign cnt_dec  = (state == CAP_POST);

  capture_trigger_controller_post_trigger_counter #(
    .WIDTH(ADDR_WIDTH)
  ) u_post_trigger_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .load_value(post_trig_count),
    .dec       (cnt_dec),
    .last      (cnt_last)
  );

  // Outputs are registered alongside the state so they always match it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CAP_IDLE;
      buf_clear    <= 1'b0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      trig_addr    <= '0;
      start_addr   <= '0;
    end else if (abort) begin
      state        <= CAP_IDLE;
      buf_clear    <= 1'b0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        CAP_IDLE, CAP_DONE: begin
          if (arm) begin
            state        <= CAP_CLEAR;
            buf_clear    <= 1'b1;
            write_enable <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        CAP_CLEAR: begin
          state        <= CAP_FILL;
          buf_clear    <= 1'b0;
          write_enable <= 1'b1;
          busy         <= 1'b1;
        end
        CAP_FILL: begin
          if (primed) begin
            state <= CAP_ARMED;
          end
        end
        CAP_ARMED: begin
          if (trigger_in) begin
            // Frozen waddr ends one past the last post-trigger write.
            trig_addr  <= waddr;
            start_addr <= waddr + post_trig_count + ADDR_WIDTH'(1);
            if (post_trig_count == '0) begin
              state        <= CAP_DONE;
              write_enable <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else begin
              state <= CAP_POST;
            end
          end
        end
        CAP_POST: begin
          if (cnt_last) begin
            state        <= CAP_DONE;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end
        end
        default: begin
          state        <= CAP_IDLE;
          buf_clear    <= 1'b0;
          write_enable <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_trigger_controller.sv
// Bench for capture_trigger_controller with a behavioural write-address counter
// and sample memory; expected capture results go through a scoreboard queue.
module tb_capture_trigger_controller;
  import capture_trigger_controller_pkg::*;

  localparam int AW = 4;

  typedef struct {
    logic [AW-1:0] trig;
    logic [AW-1:0] start;
    int            writes;
    int            data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trigger_in = 1'b0;
  logic [AW-1:0] post_trig_count = '0;
  logic [AW-1:0] waddr;
  logic          primed;
  logic          primed_q;
  logic          buf_clear;
  logic          write_enable;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;
  logic          busy;
  logic          done;

  int            mem [16];
  int            sample;
  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [AW-1:0] last_trig = '0;

  always #5 clk = ~clk;

  capture_trigger_controller #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .arm            (arm),
    .abort          (abort),
    .trigger_in     (trigger_in),
    .post_trig_count(post_trig_count),
    .waddr          (waddr),
    .primed         (primed),
    .buf_clear      (buf_clear),
    .write_enable   (write_enable),
    .trig_addr      (trig_addr),
    .start_addr     (start_addr),
    .busy           (busy),
    .done           (done)
  );

  // Write-address counter: primed is seen in the same cycle the last location is written.
  assign primed = primed_q | (write_enable && (waddr == 4'hF));

  always @(posedge clk) begin
    sample <= sample + 1;
    if (reset || buf_clear) begin
      waddr    <= '0;
      primed_q <= 1'b0;
    end else if (write_enable) begin
      mem[waddr] <= sample;
      waddr      <= waddr + 4'd1;
      if (waddr == 4'hF) primed_q <= 1'b1;
    end
  end

  initial sample = 100;

  task automatic fill(output bit ok);
    int writes = 0;
    ok = 1'b0;
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    vectors += 5;
    if (buf_clear !== 1'b1) begin miscompares++; $display("FAIL clear_pulse: got %b expected 1", buf_clear); end
    if (write_enable !== 1'b0) begin miscompares++; $display("FAIL clear_we: got %b expected 0", write_enable); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL clear_busy: got %b expected 1", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL clear_done: got %b expected 0", done); end
    if (trig_addr !== last_trig) begin miscompares++; $display("FAIL trig_hold: got %0d expected %0d", trig_addr, last_trig); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        vectors++;
        if (buf_clear !== 1'b0) begin miscompares++; $display("FAIL clear_width: got %b expected 0", buf_clear); end
      end
      if (i == 3) arm = 1'b1;
      if (i == 4) arm = 1'b0;
      if (write_enable === 1'b1) writes++;
      if (primed === 1'b1) begin ok = 1'b1; break; end
    end
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL fill_timeout: got primed=0 expected 1"); end
    if (writes != 16) begin miscompares++; $display("FAIL fill_writes: got %0d expected 16", writes); end
  endtask

  task automatic capture(input logic [AW-1:0] target, input logic [AW-1:0] n,
                         input logic [AW-1:0] n_late);
    exp_t e;
    exp_t got;
    bit   found = 1'b0;
    bit   timeout = 1'b1;
    int   writes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (waddr == target) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL armed_wait: got waddr=%0d expected %0d", waddr, target);
      trigger_in = 1'b0;
      return;
    end
    trigger_in      = 1'b1;
    post_trig_count = n;
    e.trig   = target;
    e.start  = target + n + 4'd1;
    e.writes = int'(n) + 1;
    e.data   = sample;
    sb.push_back(e);
    if (write_enable === 1'b1) writes++;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin trigger_in = 1'b0; post_trig_count = n_late; end
      if (done === 1'b1) begin timeout = 1'b0; break; end
      if (write_enable === 1'b1) writes++;
    end
    vectors++;
    if (timeout) begin miscompares++; $display("FAIL done_wait: got done=0 expected 1"); end
    if (sb.size() == 0) begin
      vectors++; miscompares++; $display("FAIL scoreboard: got empty expected entry");
      return;
    end
    got = sb.pop_front();
    last_trig = got.trig;
    vectors += 7;
    if (trig_addr !== got.trig) begin miscompares++; $display("FAIL trig_addr: got %0d expected %0d", trig_addr, got.trig); end
    if (start_addr !== got.start) begin miscompares++; $display("FAIL start_addr: got %0d expected %0d", start_addr, got.start); end
    if (writes != got.writes) begin miscompares++; $display("FAIL post_writes: got %0d expected %0d", writes, got.writes); end
    if (waddr !== got.start) begin miscompares++; $display("FAIL waddr_frozen: got %0d expected %0d", waddr, got.start); end
    if (mem[got.trig] != got.data) begin miscompares++; $display("FAIL trig_data: got %0d expected %0d", mem[got.trig], got.data); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL done_busy: got %b expected 0", busy); end
    if (write_enable !== 1'b0) begin miscompares++; $display("FAIL done_we: got %b expected 0", write_enable); end
    repeat (2) @(negedge clk);
    vectors += 2;
    if (waddr !== got.start) begin miscompares++; $display("FAIL waddr_hold: got %0d expected %0d", waddr, got.start); end
    if (done !== 1'b1) begin miscompares++; $display("FAIL done_level: got %b expected 1", done); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    arm   = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 7;
    if (buf_clear !== 1'b0) begin miscompares++; $display("FAIL rst_buf_clear: got %b expected 0", buf_clear); end
    if (write_enable !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b expected 0", write_enable); end
    if (trig_addr !== 4'd0) begin miscompares++; $display("FAIL rst_trig_addr: got %0d expected 0", trig_addr); end
    if (start_addr !== 4'd0) begin miscompares++; $display("FAIL rst_start_addr: got %0d expected 0", start_addr); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", done); end
    if (dut.state !== CAP_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d expected %0d", dut.state, CAP_IDLE); end
    reset = 1'b0;
    arm   = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_arm_busy: got %b expected 0", busy); end
    if (buf_clear !== 1'b0) begin miscompares++; $display("FAIL rst_arm_clear: got %b expected 0", buf_clear); end
  endtask

  task automatic test_basic();
    bit ok;
    fill(ok);
    if (ok) capture(4'd5, 4'd3, 4'd9);
  endtask

  task automatic test_n_zero();
    bit ok;
    fill(ok);
    if (ok) capture(4'd12, 4'd0, 4'd7);
  endtask

  task automatic test_wrap();
    bit ok;
    fill(ok);
    if (ok) capture(4'd14, 4'd15, 4'd2);
  endtask

  task automatic test_early_trigger();
    bit ok;
    trigger_in = 1'b1;
    fill(ok);
    if (ok) capture(4'd0, 4'd2, 4'd0);
    trigger_in = 1'b0;
  endtask

  task automatic test_abort();
    bit            ok;
    bit            found = 1'b0;
    logic [AW-1:0] w;
    fill(ok);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (waddr == 4'd3) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL abort_wait: got waddr=%0d expected 3", waddr); end
    trigger_in      = 1'b1;
    post_trig_count = 4'd10;
    @(negedge clk) trigger_in = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    vectors += 4;
    if (write_enable !== 1'b0) begin miscompares++; $display("FAIL abort_we: got %b expected 0", write_enable); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b expected 0", done); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (trig_addr !== 4'd3) begin miscompares++; $display("FAIL abort_trig_addr: got %0d expected 3", trig_addr); end
    last_trig = 4'd3;
    w = waddr;
    @(negedge clk);
    vectors++;
    if (waddr !== w) begin miscompares++; $display("FAIL abort_frozen: got %0d expected %0d", waddr, w); end
    arm   = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    arm   = 1'b0;
    abort = 1'b0;
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL arm_abort_busy: got %b expected 0", busy); end
    if (buf_clear !== 1'b0) begin miscompares++; $display("FAIL arm_abort_clear: got %b expected 0", buf_clear); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL arm_abort_idle: got %b expected 0", busy); end
    fill(ok);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    vectors += 3;
    if (write_enable !== 1'b0) begin miscompares++; $display("FAIL midrst_we: got %b expected 0", write_enable); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (trig_addr !== 4'd0) begin miscompares++; $display("FAIL midrst_trig_addr: got %0d expected 0", trig_addr); end
    last_trig = 4'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_n_zero();
    test_wrap();
    test_early_trigger();
    test_abort();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_left: got %0d expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
